// File: rtl/load_store_initiator.sv
// load_store_initiator: MEM-stage load/store requester for a word-wide data memory.
// Turns a byte address plus Funct3 into word accesses. An access that crosses a word
// boundary is split into two consecutive word accesses, and the two read words are
// merged before the load result is extended. busy holds the pipeline until done pulses.
module load_store_initiator #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   input  logic                    MemRead,
   input  logic                    MemWrite,
   input  logic [2:0]              Funct3,
   input  logic [DM_ADDRESS-1:0]   a,
   input  logic [DATA_W-1:0]       wd,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [DATA_W-1:0]       rd,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DM_ADDRESS-3:0]   mem_addr,
   output logic [3:0]              mem_be,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_ack
);

   localparam int WA = DM_ADDRESS - 2;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t              state;
   logic [2:0]          f3_r;
   logic [1:0]          off_r;
   logic [7:0]          m_r;
   logic                ld_r;
   logic [DATA_W-1:0]   wd_r;
   logic [DATA_W-1:0]   lo_r;

   logic [7:0]          base;
   logic [7:0]          mask_in;
   logic                legal;
   logic [5:0]          rsh;
   logic [63:0]         pair;
   logic [63:0]         pair_sh;
   logic [31:0]         v;
   logic [DATA_W-1:0]   ld_val;
   logic [WA-1:0]       addr_inc;

   assign busy     = (state != IDLE);
   assign rsh      = 6'd32 - {1'b0, off_r, 3'b000};
   assign addr_inc = mem_addr + {{(WA-1){1'b0}}, 1'b1};

   // Request decode: lane mask from size and byte offset, and Funct3 legality per op.
   always_comb begin
      base = 8'h00;
      case (Funct3[1:0])
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         default: base = 8'h0F;
      endcase
      mask_in = base << a[1:0];
      legal   = 1'b0;
      if (MemRead ^ MemWrite) begin
         if (MemRead)
            legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b101);
         else
            legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
      end
   end

   // Load result: merge the two read words (hi is the live read word in ACC1), shift the
   // addressed bytes down, then sign- or zero-extend by size.
   always_comb begin
      pair = 64'h0;
      if (state == ACC1) pair = {mem_rdata, lo_r};
      else               pair = {32'h0, mem_rdata};
      pair_sh = pair >> {off_r, 3'b000};
      v       = pair_sh[31:0];
      case (f3_r)
         3'b000:  ld_val = {{24{v[7]}}, v[7:0]};
         3'b001:  ld_val = {{16{v[15]}}, v[15:0]};
         3'b100:  ld_val = {24'h0, v[7:0]};
         3'b101:  ld_val = {16'h0, v[15:0]};
         default: ld_val = v;
      endcase
   end

   // Control FSM with registered memory-port and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         done      <= 1'b0;
         err       <= 1'b0;
         rd        <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'h0;
         mem_wdata <= '0;
         f3_r      <= 3'b000;
         off_r     <= 2'b00;
         m_r       <= 8'h00;
         ld_r      <= 1'b0;
         wd_r      <= '0;
         lo_r      <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (req_valid && (MemRead || MemWrite)) begin
                  if (legal) begin
                     state     <= ACC0;
                     f3_r      <= Funct3;
                     off_r     <= a[1:0];
                     m_r       <= mask_in;
                     ld_r      <= MemRead;
                     wd_r      <= wd;
                     mem_req   <= 1'b1;
                     mem_we    <= MemWrite;
                     mem_addr  <= a[DM_ADDRESS-1:2];
                     mem_be    <= mask_in[3:0];
                     mem_wdata <= wd << {a[1:0], 3'b000};
                  end else begin
                     // Rejected request: respond immediately, memory untouched.
                     state <= RESP;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            ACC0: begin
               if (mem_ack) begin
                  lo_r <= mem_rdata;
                  if (|m_r[7:4]) begin
                     state     <= ACC1;
                     mem_addr  <= addr_inc;
                     mem_be    <= m_r[7:4];
                     mem_wdata <= wd_r >> rsh;
                  end else begin
                     state   <= RESP;
                     mem_req <= 1'b0;
                     mem_we  <= 1'b0;
                     mem_be  <= 4'h0;
                     done    <= 1'b1;
                     if (ld_r) rd <= ld_val;
                  end
               end
            end
            ACC1: begin
               if (mem_ack) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= 4'h0;
                  done    <= 1'b1;
                  if (ld_r) rd <= ld_val;
               end
            end
            default: begin
               // RESP: done/err were a one-cycle pulse; next request accepted in IDLE.
               done  <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_initiator.sv
// Directed bench for load_store_initiator with a small word-memory model whose ack
// delay is programmable (0 = same-cycle ack).
module tb_load_store_initiator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [8:0]  a;
   logic [31:0] wd;
   logic        busy, done, err;
   logic [31:0] rd;
   logic        mem_req, mem_we;
   logic [6:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ack;

   always #5 clk = ~clk;

   load_store_initiator #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .MemRead(MemRead),
      .MemWrite(MemWrite), .Funct3(Funct3), .a(a), .wd(wd), .busy(busy),
      .done(done), .err(err), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   typedef struct {
      logic [6:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } acc_t;

   logic [31:0] mem [0:127];
   int          ack_dly = 0;
   int          wait_cnt = 0;
   acc_t        acc_q[$];

   assign mem_ack   = mem_req && (wait_cnt >= ack_dly);
   assign mem_rdata = mem[mem_addr];

   // Memory model: count wait cycles, commit byte-enabled writes, log completed accesses.
   always @(posedge clk) begin
      acc_t e;
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
      if (mem_req && mem_ack) begin
         e.addr = mem_addr; e.be = mem_be; e.wdata = mem_wdata; e.we = mem_we;
         acc_q.push_back(e);
         if (mem_we)
            for (int i = 0; i < 4; i++)
               if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   int n_asrt = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   int dcyc, bcyc, acyc, hbad;
   logic derr;

   // Drive one request and follow it to done (bounded); reports done cycle, busy cycles,
   // last ack cycle, output-hold violations while waiting, and err at done.
   task automatic issue(input logic r, input logic w, input logic [2:0] f,
                        input logic [8:0] ad, input logic [31:0] d);
      logic        have;
      logic [6:0]  pa;
      logic [3:0]  pb;
      logic [31:0] pw;
      @(negedge clk);
      acc_q.delete();
      req_valid = 1'b1; MemRead = r; MemWrite = w; Funct3 = f; a = ad; wd = d;
      dcyc = 0; bcyc = 0; acyc = -1; hbad = 0; derr = 1'b0; have = 1'b0;
      pa = '0; pb = '0; pw = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy) bcyc++;
         if (mem_req) begin
            if (have && (mem_addr !== pa || mem_be !== pb || mem_wdata !== pw)) hbad++;
            pa = mem_addr; pb = mem_be; pw = mem_wdata;
            have = !mem_ack;
         end else if (have) begin
            hbad++;
            have = 1'b0;
         end
         if (mem_ack) acyc = c;
         if (done) begin
            dcyc = c; derr = err;
            break;
         end
      end
      req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      if (dcyc == 0) chk("done_timeout", 32'(dcyc), 32'd1);
   endtask

   initial begin
      int q;
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      Funct3 = 3'b000; a = '0; wd = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done_err", {30'b0, done, err}, 32'd0);
      chk("rst_req_we", {30'b0, mem_req, mem_we}, 32'd0);
      chk("rst_be_addr", {21'b0, mem_be, mem_addr}, 32'd0);
      chk("rst_rd", rd, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // aligned SW
      issue(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
      chk("sw_nacc", acc_q.size(), 32'd1);
      chk("sw_addr", {25'b0, acc_q[0].addr}, 32'h04);
      chk("sw_be", {28'b0, acc_q[0].be}, 32'hF);
      chk("sw_wdata", acc_q[0].wdata, 32'hDEADBEEF);
      chk("sw_we", {31'b0, acc_q[0].we}, 32'd1);
      chk("sw_lat", 32'(dcyc), 32'd2);
      chk("sw_busy", 32'(bcyc), 32'd2);
      chk("sw_err", {31'b0, derr}, 32'd0);
      @(negedge clk);
      chk("sw_idle", {31'b0, busy}, 32'd0);

      // SB to top lane, then LB / LBU of it
      issue(1'b0, 1'b1, 3'b000, 9'h013, 32'h000000A5);
      chk("sb_be", {28'b0, acc_q[0].be}, 32'h8);
      chk("sb_wdata", acc_q[0].wdata, 32'hA5000000);
      chk("sb_mem", mem[4], 32'hA5ADBEEF);
      issue(1'b1, 1'b0, 3'b000, 9'h013, 32'h0);
      chk("lb_rd", rd, 32'hFFFFFFA5);
      chk("lb_we", {31'b0, acc_q[0].we}, 32'd0);
      issue(1'b1, 1'b0, 3'b100, 9'h013, 32'h0);
      chk("lbu_rd", rd, 32'h000000A5);

      // misaligned LW across words 1/2
      mem[1] = 32'h44332211; mem[2] = 32'h88776655;
      issue(1'b1, 1'b0, 3'b010, 9'h006, 32'h0);
      chk("lw_nacc", acc_q.size(), 32'd2);
      chk("lw_addr0", {25'b0, acc_q[0].addr}, 32'h01);
      chk("lw_addr1", {25'b0, acc_q[1].addr}, 32'h02);
      chk("lw_be", {24'b0, acc_q[1].be, acc_q[0].be}, 32'h3C);
      chk("lw_rd", rd, 32'h66554433);
      chk("lw_lat", 32'(dcyc), 32'd3);
      chk("lw_busy", 32'(bcyc), 32'd3);

      // misaligned SH wrapping the word address
      issue(1'b0, 1'b1, 3'b001, 9'h1FF, 32'h0000BBAA);
      chk("sh_nacc", acc_q.size(), 32'd2);
      chk("sh_addr0", {25'b0, acc_q[0].addr}, 32'h7F);
      chk("sh_be0", {28'b0, acc_q[0].be}, 32'h8);
      chk("sh_wd0", acc_q[0].wdata, 32'hAA000000);
      chk("sh_addr1", {25'b0, acc_q[1].addr}, 32'h00);
      chk("sh_be1", {28'b0, acc_q[1].be}, 32'h1);
      chk("sh_wd1_lo", {24'b0, acc_q[1].wdata[7:0]}, 32'hBB);
      issue(1'b1, 1'b0, 3'b001, 9'h1FF, 32'h0);
      chk("lh_wrap_rd", rd, 32'hFFFFBBAA);
      issue(1'b1, 1'b0, 3'b101, 9'h1FF, 32'h0);
      chk("lhu_wrap_rd", rd, 32'h0000BBAA);

      // delayed ack: outputs held, done one cycle after ack
      ack_dly = 3;
      issue(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
      chk("dly_rd", rd, 32'hA5ADBEEF);
      chk("dly_hold", 32'(hbad), 32'd0);
      chk("dly_ack_cyc", 32'(acyc), 32'd4);
      chk("dly_done_after_ack", 32'(dcyc), 32'(acyc + 1));
      chk("dly_busy", 32'(bcyc), 32'(dcyc));
      ack_dly = 0;

      // illegal requests
      issue(1'b1, 1'b0, 3'b011, 9'h010, 32'h0);
      chk("ill_f3_nacc", acc_q.size(), 32'd0);
      chk("ill_f3_err", {31'b0, derr}, 32'd1);
      chk("ill_f3_rd", rd, 32'hA5ADBEEF);
      issue(1'b1, 1'b1, 3'b010, 9'h010, 32'h12345678);
      chk("ill_rw_nacc", acc_q.size(), 32'd0);
      chk("ill_rw_err", {31'b0, derr}, 32'd1);
      chk("ill_rw_rd", rd, 32'hA5ADBEEF);
      issue(1'b0, 1'b1, 3'b100, 9'h010, 32'h0);
      chk("ill_sbu_err", {31'b0, derr}, 32'd1);
      chk("ill_sbu_mem", mem[4], 32'hA5ADBEEF);

      // req_valid with no op is ignored
      @(negedge clk);
      req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
      q = 0;
      repeat (3) begin
         @(negedge clk);
         q += int'(busy) + int'(mem_req) + int'(done);
      end
      req_valid = 1'b0;
      chk("noop_ignored", 32'(q), 32'd0);

      // reset while waiting in ACC1
      ack_dly = 5;
      @(negedge clk);
      req_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; a = 9'h006;
      q = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 7'h02) begin
            q = 1;
            break;
         end
      end
      chk("rst_reach_acc1", 32'(q), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_req", {31'b0, mem_req}, 32'd0);
      chk("mrst_outs", {26'b0, busy, done, err, mem_we, |mem_be, |mem_addr}, 32'd0);
      chk("mrst_data", rd | mem_wdata, 32'd0);
      req_valid = 1'b0; MemRead = 1'b0; ack_dly = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("mrst_idle", {30'b0, busy, mem_req}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
